prev_knn_sched: RTL and testbench

//  Sequences the previous query's K-nearest-neighbour list through the comparator for each new query.

---
 rtl/prev_knn_sched_if.sv | 26 ++
 rtl/prev_knn_sched.sv | 113 +++++++++++
 tb/tb_prev_knn_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prev_knn_sched_if.sv
// prev_knn_sched_if: control, prev-KNN buffer read port and comparator/topK stream of the scheduler.
// An entry is {valid, distance}; valid sits in the MSB.
interface prev_knn_sched_if #(
    parameter int K      = 8,
    parameter int LOG2K  = 3,
    parameter int DIST_W = 16
);
    logic              start;
    logic              rd_en;
    logic [LOG2K-1:0]  rd_addr;
    logic [DIST_W:0]   rd_data;
    logic [DIST_W:0]   cmp_entry;
    logic [DIST_W-1:0] running_mean;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    modport master (
        input  start, rd_data, out_ready,
        output rd_en, rd_addr, cmp_entry, running_mean, out_valid, busy, done
    );
    modport slave (
        output start, rd_data, out_ready,
        input  rd_en, rd_addr, cmp_entry, running_mean, out_valid, busy, done
    );
endinterface

// File: rtl/prev_knn_sched.sv
// prev_knn_sched: two-pass sequencer over the previous query's KNN list.
// Pass 1 averages valid distances into running_mean; pass 2 streams every entry to the comparator.
module prev_knn_sched #(
    parameter int K      = 8,
    parameter int LOG2K  = 3,
    parameter int DIST_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    prev_knn_sched_if.master bus
);
    localparam int CW = LOG2K + 1;
    localparam int SW = DIST_W + LOG2K;
    localparam int EW = DIST_W + 1;

    typedef enum logic [2:0] {IDLE, SUM, MEAN, STREAM, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] iss_q, iss_d;
    logic [CW-1:0] xc_q, xc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [DIST_W-1:0] rm_q, rm_d;
    logic          pend_q, pend_d;
    logic          sk_v_q, sk_v_d;
    logic [EW-1:0] sk_e_q, sk_e_d;
    logic          out_valid, xfer, rd_en;
    logic [EW-1:0] cmp_entry;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            iss_q   <= '0;
            xc_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            rm_q    <= '1;
            pend_q  <= 1'b0;
            sk_v_q  <= 1'b0;
            sk_e_q  <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            xc_q    <= xc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            rm_q    <= rm_d;
            pend_q  <= pend_d;
            sk_v_q  <= sk_v_d;
            sk_e_q  <= sk_e_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? SUM : IDLE;
            SUM:     state_d = iss_q[LOG2K] ? MEAN : SUM;
            MEAN:    state_d = STREAM;
            STREAM:  state_d = (xfer && xc_q == CW'(K - 1)) ? DONE : STREAM;
            default: state_d = IDLE;
        endcase
    end

    // A stream read is issued only when the slot it lands in next cycle is guaranteed free,
    // so the skid register never needs more than one entry.
    always_comb begin
        out_valid        = state_q == STREAM && (sk_v_q || pend_q);
        xfer             = out_valid && bus.out_ready;
        cmp_entry        = sk_v_q ? sk_e_q : out_valid ? bus.rd_data : '0;
        rd_en            = !iss_q[LOG2K] && (state_q == SUM || (state_q == STREAM && (xfer || !out_valid)));
        bus.rd_en        = rd_en;
        bus.rd_addr      = iss_q[LOG2K-1:0];
        bus.cmp_entry    = cmp_entry;
        bus.out_valid    = out_valid;
        bus.running_mean = rm_q;
        bus.busy         = state_q != IDLE;
        bus.done         = state_q == DONE;
    end

    always_comb begin
        iss_d  = iss_q + CW'(rd_en);
        xc_d   = xc_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        rm_d   = rm_q;
        pend_d = rd_en;
        sk_v_d = sk_v_q;
        sk_e_d = sk_e_q;
        case (state_q)
            IDLE: if (bus.start) begin
                iss_d = '0;
                sum_d = '0;
                cnt_d = '0;
            end
            SUM: if (pend_q && bus.rd_data[DIST_W]) begin
                sum_d = sum_q + SW'(bus.rd_data[DIST_W-1:0]);
                cnt_d = cnt_q + CW'(1);
            end
            MEAN: begin
                rm_d  = cnt_q[LOG2K] ? DIST_W'(sum_q >> LOG2K) : '1;
                iss_d = '0;
                xc_d  = '0;
            end
            STREAM: begin
                xc_d   = xc_q + CW'(xfer);
                sk_v_d = out_valid && !xfer;
                sk_e_d = sk_v_d ? cmp_entry : sk_e_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prev_knn_sched.sv
// tb_prev_knn_sched: directed and randomized queries against a list-level reference model
// (expected mean from plain arithmetic, expected stream = buffer contents in address order).
module tb_prev_knn_sched;
    localparam int K = 8, LOG2K = 3, DIST_W = 16, EW = DIST_W + 1;
    localparam logic [DIST_W-1:0] ONES = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prev_knn_sched_if #(.K(K), .LOG2K(LOG2K), .DIST_W(DIST_W)) bus ();
    prev_knn_sched #(.K(K), .LOG2K(LOG2K), .DIST_W(DIST_W)) dut (.clock(clk), .reset(rst), .bus(bus));

    logic [EW-1:0] mem [K];
    always @(posedge clk) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : EW'($urandom);

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_en"}, 64'(bus.rd_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'(0));
        check({tag, "_cmp_entry"}, 64'(bus.cmp_entry), 64'(0));
        check({tag, "_mean"}, 64'(bus.running_mean), 64'(ONES));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_done"}, 64'(bus.done), 64'(0));
    endtask

    task automatic fill_rand(input bit all_valid);
        for (int i = 0; i < K; i++)
            mem[i] = {all_valid ? 1'b1 : 1'($urandom % 5 != 0), DIST_W'($urandom)};
    endtask

    // start pulses at cycles s1..s3 (cycle 1 is the first cycle after start is accepted)
    task automatic run_query(input string name, input int stall_at, input bit rand_ready,
                             input int rst_after, input int s1, input int s2, input int s3);
        logic [EW-1:0] got [$];
        logic [EW-1:0] prev_e;
        logic [DIST_W-1:0] exp_mean;
        longint sum = 0;
        int cnt = 0, c = 0, done_cyc = -1, dones = 0, stall_left = 3, busy_drop = 0, idle_bad = 0;
        bit prev_stall = 0;
        for (int i = 0; i < K; i++)
            if (mem[i][DIST_W]) begin
                cnt++;
                sum += longint'(mem[i][DIST_W-1:0]);
            end
        exp_mean = (cnt == K) ? DIST_W'(sum / K) : ONES;
        @(negedge clk);
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        while (dones == 0 && c < 80) begin
            c++;
            @(negedge clk);
            bus.start = (c == s1 || c == s2 || c == s3);
            if (rst_after >= 0 && got.size() == rst_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                bus.start = 1'b0;
                #1;
                check_reset({name, "_midrst"});
                return;
            end
            if (rand_ready) bus.out_ready = ($urandom % 3 != 0);
            else if (stall_at >= 0 && got.size() == stall_at && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else bus.out_ready = 1'b1;
            #1;
            if (prev_stall) begin
                check({name, "_stall_valid"}, 64'(bus.out_valid), 64'(1));
                check({name, "_stall_entry"}, 64'(bus.cmp_entry), 64'(prev_e));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_e = bus.cmp_entry;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.cmp_entry);
            if (!bus.busy) busy_drop++;
            if (bus.done) begin
                dones++;
                done_cyc = c;
            end
        end
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (bus.busy || bus.done) idle_bad++;
        end
        check({name, "_done_seen"}, 64'(dones), 64'(1));
        check({name, "_busy_drop"}, 64'(busy_drop), 64'(0));
        check({name, "_idle_after"}, 64'(idle_bad), 64'(0));
        check({name, "_mean"}, 64'(bus.running_mean), 64'(exp_mean));
        check({name, "_xfers"}, 64'(got.size()), 64'(K));
        if (got.size() == K)
            for (int i = 0; i < K; i++) check({name, "_entry"}, 64'(got[i]), 64'(mem[i]));
        if (!rand_ready && stall_at < 0) check({name, "_done_cycle"}, 64'(done_cyc), 64'(2 * K + 4));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < K; i++) mem[i] = {1'b1, DIST_W'((i + 1) * 8)};
        run_query("t1_allvalid", -1, 0, -1, -1, -1, -1);
        check("t1_mean_36", 64'(bus.running_mean), 64'(36));

        mem[5][DIST_W] = 1'b0;
        mem[7][DIST_W] = 1'b0;
        run_query("t2_partial", -1, 0, -1, -1, -1, -1);
        check("t2_mean_ones", 64'(bus.running_mean), 64'(ONES));

        for (int i = 0; i < K; i++) mem[i] = {1'b1, DIST_W'((i + 1) * 8)};
        run_query("t3_stall", 2, 0, -1, -1, -1, -1);

        fill_rand(1);
        run_query("t4_ignored_start", -1, 0, -1, 3, 14, 2 * K + 4);

        fill_rand(1);
        run_query("t5_reset", -1, 0, 4, -1, -1, -1);
        fill_rand(0);
        run_query("t5_rerun", -1, 0, -1, -1, -1, -1);

        for (int i = 0; i < K; i++) mem[i] = {1'b1, ONES};
        run_query("t6_max", -1, 0, -1, -1, -1, -1);
        check("t6_mean_max", 64'(bus.running_mean), 64'(ONES));

        for (int r = 0; r < 6; r++) begin
            fill_rand(r % 2 == 0);
            run_query("rand", -1, 1, -1, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
